// File: rtl/noc_inject_arbiter.sv
// Wormhole-aware round-robin injection arbiter sharing a router's local input port among NUM_REQ requesters.
// Optional build macro NOC_INJECT_PKT_COUNT_EN adds the pkt_count / flit_count statistics outputs.
module noc_inject_arbiter #(
    parameter int LINK_WIDTHS = 8,
    parameter int NUM_REQ     = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [LINK_WIDTHS*NUM_REQ-1:0] req_flit_flat,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           router_full,
    output logic [LINK_WIDTHS-1:0]         out_flit,
    output logic                           out_wr_en,
    output logic [ID_W-1:0]                grant_id,
    output logic                           busy,
`ifdef NOC_INJECT_PKT_COUNT_EN
    output logic [15:0]                    pkt_count,
    output logic [15:0]                    flit_count,
`endif
    output logic                           proto_err
);

    localparam logic [1:0]      FT_HEAD   = 2'b10;
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state, state_next;

    logic [ID_W-1:0]        rr_ptr, rr_ptr_next;
    logic [ID_W-1:0]        grant_next;
    logic [ID_W-1:0]        pick;
    logic                   found;
    logic                   err_set;

    logic [LINK_WIDTHS-1:0] flit [NUM_REQ];
    logic [NUM_REQ-1:0]     cand;
    logic [NUM_REQ-1:0]     stray;

    logic [LINK_WIDTHS-1:0] owner_flit;
    logic [1:0]             owner_type;
    logic                   owner_valid;
    logic                   xfer;
    logic                   last_flit;

    // Handshake: a flit moves when req_valid[r] && req_ready[r]; ready is only ever
    // offered to the locked owner while the router is not full, and never in IDLE.
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
        assign flit[r]      = req_flit_flat[r*LINK_WIDTHS +: LINK_WIDTHS];
        assign cand[r]      = req_valid[r] && flit[r][LINK_WIDTHS-1];
        assign stray[r]     = req_valid[r] && !flit[r][LINK_WIDTHS-1];
        assign req_ready[r] = (state == LOCKED) && (grant_id == ID_W'(r)) && !router_full;
    end

    assign owner_flit  = flit[grant_id];
    assign owner_type  = owner_flit[LINK_WIDTHS-1 -: 2];
    assign owner_valid = req_valid[grant_id];
    assign xfer        = (state == LOCKED) && owner_valid && !router_full;
    assign last_flit   = owner_type[0];
    assign busy        = (state == LOCKED);

    // Search upward from rr_ptr with wrap; the first packet-starting candidate wins.
    always_comb begin
        logic [ID_W:0] slot;
        found = 1'b0;
        pick  = '0;
        slot  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (slot >= NUM_REQ_W) begin
                slot = slot - NUM_REQ_W;
            end
            if (!found && cand[slot[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = slot[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_next  = state;
        grant_next  = grant_id;
        rr_ptr_next = rr_ptr;
        err_set     = 1'b0;
        case (state)
            IDLE: begin
                if (|stray) begin
                    err_set = 1'b1;
                end
                if (found) begin
                    state_next = LOCKED;
                    grant_next = pick;
                end
            end
            LOCKED: begin
                if (xfer && (owner_type == FT_HEAD)) begin
                    err_set = 1'b1;
                end
                if (xfer && last_flit) begin
                    state_next  = IDLE;
                    rr_ptr_next = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            proto_err <= 1'b0;
            out_wr_en <= 1'b0;
            out_flit  <= '0;
        end else begin
            state     <= state_next;
            rr_ptr    <= rr_ptr_next;
            grant_id  <= grant_next;
            proto_err <= proto_err | err_set;
            out_wr_en <= xfer;
            if (xfer) begin
                out_flit <= owner_flit;
            end
        end
    end

`ifdef NOC_INJECT_PKT_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count  <= '0;
            flit_count <= '0;
        end else if (xfer) begin
            flit_count <= flit_count + 16'd1;
            if (last_flit) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end
`endif

endmodule
